// File: rtl/dc_arb.sv
// Two-port data-cache request arbiter with in-order load response routing and port-0 flush squashing.
// Optional starvation relief for port 1 is built when DC_ARB_STARVE_EN is defined.
module dc_arb #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic [3:0]  p0_op,
    input  logic [31:0] p0_addr,
    input  logic [4:0]  p0_tag,
    input  logic [31:0] p0_wdata,
    output logic        p0_ready,
    input  logic        p0_flush,
    output logic        p0_valid,
    output logic        p0_error,
    output logic [4:0]  p0_rtag,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic [3:0]  p1_op,
    input  logic [31:0] p1_addr,
    input  logic [4:0]  p1_tag,
    input  logic [31:0] p1_wdata,
    output logic        p1_ready,
    output logic        p1_valid,
    output logic        p1_error,
    output logic [4:0]  p1_rtag,
    output logic [31:0] p1_rdata,

    output logic        dc_req,
    output logic [3:0]  dc_op,
    output logic [31:0] dc_addr,
    output logic [5:0]  dc_tag,
    output logic [31:0] dc_wdata,
    input  logic        dc_ready,
    input  logic        dc_valid,
    input  logic        dc_error,
    input  logic [5:0]  dc_rtag,
    input  logic [31:0] dc_rdata
);

    localparam int CW = $clog2(MAX_OUT) + 1;

    generate
        if (MAX_OUT < 2 || MAX_OUT > 8 || (MAX_OUT & (MAX_OUT - 1)) != 0) begin : g_bad_max_out
            $error("dc_arb: MAX_OUT must be a power of two in 2..8");
        end
        if (STARVE_LIM < 1) begin : g_bad_starve_lim
            $error("dc_arb: STARVE_LIM must be at least 1");
        end
    endgenerate

    logic [CW-1:0] r_out0;
    logic [CW-1:0] r_out1;
    logic [CW-1:0] r_sq;

    logic w_ld0, w_ld1;
    logic w_elig0, w_elig1;
    logic w_force;
    logic w_sel1;
    logic w_beat;
    logic w_iss0, w_iss1;
    logic w_ret0, w_ret1;
    logic w_squash;

    assign w_ld0 = ~p0_op[0];
    assign w_ld1 = ~p1_op[0];

    // A flushing port 0 is kept off the bus so downstream never accepts a beat p0 thinks was refused.
    assign w_elig0 = p0_req & ~p0_flush & (~w_ld0 | (r_out0 < CW'(MAX_OUT)));
    assign w_elig1 = p1_req & (~w_ld1 | (r_out1 < CW'(MAX_OUT)));

    assign w_sel1 = w_elig1 & (~w_elig0 | w_force);

    assign dc_req   = rst_n & (w_elig0 | w_elig1);
    assign dc_op    = w_sel1 ? p1_op    : p0_op;
    assign dc_addr  = w_sel1 ? p1_addr  : p0_addr;
    assign dc_wdata = w_sel1 ? p1_wdata : p0_wdata;
    assign dc_tag   = w_sel1 ? {1'b1, p1_tag} : {1'b0, p0_tag};

    assign w_beat   = dc_req & dc_ready;
    assign p0_ready = w_beat & ~w_sel1;
    assign p1_ready = w_beat & w_sel1;

    assign w_iss0 = p0_ready & w_ld0;
    assign w_iss1 = p1_ready & w_ld1;

    // Responses with no matching outstanding load (e.g. issued before reset) are ignored entirely.
    assign w_ret0   = rst_n & dc_valid & ~dc_rtag[5] & (r_out0 != '0);
    assign w_ret1   = rst_n & dc_valid &  dc_rtag[5] & (r_out1 != '0);
    assign w_squash = (r_sq != '0);

    assign p0_valid = w_ret0 & ~w_squash;
    assign p0_error = p0_valid & dc_error;
    assign p0_rtag  = dc_rtag[4:0];
    assign p0_rdata = dc_rdata;

    assign p1_valid = w_ret1;
    assign p1_error = w_ret1 & dc_error;
    assign p1_rtag  = dc_rtag[4:0];
    assign p1_rdata = dc_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out0 <= '0;
            r_out1 <= '0;
            r_sq   <= '0;
        end else begin
            r_out0 <= r_out0 + CW'(w_iss0) - CW'(w_ret0);
            r_out1 <= r_out1 + CW'(w_iss1) - CW'(w_ret1);
            if (p0_flush) begin
                r_sq <= r_out0 - CW'(w_ret0);
            end else if (w_ret0 && w_squash) begin
                r_sq <= r_sq - 1'b1;
            end
        end
    end

`ifdef DC_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0] r_starve;

    assign w_force = (r_starve >= SW'(STARVE_LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!w_elig1 || p1_ready) begin
            r_starve <= '0;
        end else if (p0_ready && !w_force) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

endmodule

// File: tb/tb_dc_arb.sv
// Directed self-checking bench for dc_arb: grant limits, response routing, flush squash, stores,
// asynchronous reset and port-1 starvation behaviour (DC_ARB_STARVE_EN selects the expectation).
module tb_dc_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_flush;
    logic [3:0]  p0_op;
    logic [31:0] p0_addr, p0_wdata;
    logic [4:0]  p0_tag;
    logic        p0_ready, p0_valid, p0_error;
    logic [4:0]  p0_rtag;
    logic [31:0] p0_rdata;
    logic        p1_req;
    logic [3:0]  p1_op;
    logic [31:0] p1_addr, p1_wdata;
    logic [4:0]  p1_tag;
    logic        p1_ready, p1_valid, p1_error;
    logic [4:0]  p1_rtag;
    logic [31:0] p1_rdata;
    logic        dc_req;
    logic [3:0]  dc_op;
    logic [31:0] dc_addr, dc_wdata;
    logic [5:0]  dc_tag;
    logic        dc_ready, dc_valid, dc_error;
    logic [5:0]  dc_rtag;
    logic [31:0] dc_rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dc_arb #(.MAX_OUT(4), .STARVE_LIM(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_op(p0_op), .p0_addr(p0_addr), .p0_tag(p0_tag), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_flush(p0_flush),
        .p0_valid(p0_valid), .p0_error(p0_error), .p0_rtag(p0_rtag), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_op(p1_op), .p1_addr(p1_addr), .p1_tag(p1_tag), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready),
        .p1_valid(p1_valid), .p1_error(p1_error), .p1_rtag(p1_rtag), .p1_rdata(p1_rdata),
        .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_tag(dc_tag), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_valid(dc_valid), .dc_error(dc_error), .dc_rtag(dc_rtag), .dc_rdata(dc_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; p0_req = 1'b1; p0_op = 4'h0; p0_addr = '0; p0_tag = '0; p0_wdata = '0; p0_flush = 1'b0;
        p1_req = 1'b0; p1_op = 4'h0; p1_addr = '0; p1_tag = '0; p1_wdata = '0;
        dc_ready = 1'b1; dc_valid = 1'b1; dc_error = 1'b0; dc_rtag = 6'h00; dc_rdata = '0;
        #3;
        $display("txn reset: asserted with p0_req and dc_valid high");
        n_total++; if (p0_ready !== 1'b0) $display("FAIL rst_p0_ready got %b want 0", p0_ready); else n_pass++;
        n_total++; if (dc_req !== 1'b0)   $display("FAIL rst_dc_req got %b want 0", dc_req); else n_pass++;
        n_total++; if (p0_valid !== 1'b0) $display("FAIL rst_p0_valid got %b want 0", p0_valid); else n_pass++;
        tick();
        rst_n = 1'b1; p0_req = 1'b0; dc_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_limit();
        p0_req = 1'b1; p0_op = 4'h0; p1_req = 1'b1; p1_op = 4'h0; p1_tag = 5'd0; dc_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p0_tag = 5'(k); p0_addr = 32'h1000 + 32'(k * 4);
            #1;
            $display("txn p0 load tag %0d", k);
            n_total++; if (p0_ready !== 1'b1) $display("FAIL ld_p0_ready%0d got %b want 1", k, p0_ready); else n_pass++;
            n_total++; if (dc_tag !== {1'b0, 5'(k)}) $display("FAIL ld_dc_tag%0d got %h want %h", k, dc_tag, {1'b0, 5'(k)}); else n_pass++;
            tick();
        end
        #1;
        $display("txn p1 load tag 0 while p0 at limit");
        n_total++; if (p0_ready !== 1'b0) $display("FAIL ld_p0_blocked got %b want 0", p0_ready); else n_pass++;
        n_total++; if (p1_ready !== 1'b1) $display("FAIL ld_p1_ready got %b want 1", p1_ready); else n_pass++;
        n_total++; if (dc_tag !== 6'h20)  $display("FAIL ld_p1_tag got %h want 20", dc_tag); else n_pass++;
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic test_responses();
        dc_valid = 1'b1; dc_rtag = 6'h25; dc_rdata = 32'hDEADBEEF;
        #1;
        $display("txn response rtag 25 rdata deadbeef");
        n_total++; if (p1_valid !== 1'b1) $display("FAIL rsp_p1_valid got %b want 1", p1_valid); else n_pass++;
        n_total++; if (p1_rtag !== 5'd5) $display("FAIL rsp_p1_rtag got %0d want 5", p1_rtag); else n_pass++;
        n_total++; if (p1_rdata !== 32'hDEADBEEF) $display("FAIL rsp_p1_rdata got %h want deadbeef", p1_rdata); else n_pass++;
        n_total++; if (p0_valid !== 1'b0) $display("FAIL rsp_p0_quiet got %b want 0", p0_valid); else n_pass++;
        tick();
        for (int k = 0; k < 4; k++) begin
            dc_rtag = {1'b0, 5'(k)}; dc_rdata = 32'(100 + k);
            #1;
            $display("txn p0 response tag %0d", k);
            n_total++; if (p0_valid !== 1'b1) $display("FAIL rsp_p0_valid%0d got %b want 1", k, p0_valid); else n_pass++;
            n_total++; if (p0_rtag !== 5'(k)) $display("FAIL rsp_p0_rtag%0d got %0d want %0d", k, p0_rtag, k); else n_pass++;
            tick();
        end
        dc_rtag = 6'h00;
        #1;
        $display("txn stray p0 response with nothing outstanding");
        n_total++; if (p0_valid !== 1'b0) $display("FAIL rsp_stray got %b want 0", p0_valid); else n_pass++;
        tick();
        dc_valid = 1'b0;
    endtask

    task automatic test_flush();
        p0_req = 1'b1; p0_op = 4'h0;
        for (int k = 1; k <= 2; k++) begin
            p0_tag = 5'(k);
            #1;
            $display("txn p0 load tag %0d before flush", k);
            n_total++; if (p0_ready !== 1'b1) $display("FAIL fl_issue%0d got %b want 1", k, p0_ready); else n_pass++;
            tick();
        end
        p0_flush = 1'b1; p0_tag = 5'd3;
        #1;
        $display("txn p0 flush");
        n_total++; if (p0_ready !== 1'b0) $display("FAIL fl_ready got %b want 0", p0_ready); else n_pass++;
        n_total++; if (dc_req !== 1'b0)   $display("FAIL fl_dc_req got %b want 0", dc_req); else n_pass++;
        tick();
        p0_flush = 1'b0; p0_req = 1'b0; dc_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            dc_rtag = {1'b0, 5'(k)};
            #1;
            $display("txn squashed response tag %0d", k);
            n_total++; if (p0_valid !== 1'b0) $display("FAIL fl_squash%0d got %b want 0", k, p0_valid); else n_pass++;
            tick();
        end
        dc_valid = 1'b0; p0_req = 1'b1; p0_tag = 5'd7;
        tick();
        p0_req = 1'b0; dc_valid = 1'b1; dc_rtag = 6'h07;
        #1;
        $display("txn post-flush response tag 7");
        n_total++; if (p0_valid !== 1'b1) $display("FAIL fl_fresh_valid got %b want 1", p0_valid); else n_pass++;
        n_total++; if (p0_rtag !== 5'd7)  $display("FAIL fl_fresh_rtag got %0d want 7", p0_rtag); else n_pass++;
        tick();
        dc_valid = 1'b0;
    endtask

    task automatic test_store();
        p0_req = 1'b1; p0_op = 4'h0;
        for (int k = 0; k < 4; k++) begin
            p0_tag = 5'(k);
            tick();
        end
        p0_op = 4'h1; p0_addr = 32'hA0; p0_wdata = 32'h11;
        #1;
        $display("txn p0 store at load limit");
        n_total++; if (p0_ready !== 1'b1) $display("FAIL st_ready got %b want 1", p0_ready); else n_pass++;
        n_total++; if (dc_op !== 4'h1)    $display("FAIL st_dc_op got %h want 1", dc_op); else n_pass++;
        tick();
        dc_ready = 1'b0; p0_addr = 32'hB4; p0_wdata = 32'h55;
        #1;
        $display("txn p0 store stalled");
        n_total++; if (dc_req !== 1'b1)   $display("FAIL st_stall_req got %b want 1", dc_req); else n_pass++;
        n_total++; if (p0_ready !== 1'b0) $display("FAIL st_stall_ready got %b want 0", p0_ready); else n_pass++;
        tick();
        n_total++; if (dc_addr !== 32'hB4)  $display("FAIL st_hold_addr got %h want b4", dc_addr); else n_pass++;
        n_total++; if (dc_wdata !== 32'h55) $display("FAIL st_hold_wdata got %h want 55", dc_wdata); else n_pass++;
        n_total++; if (p1_valid !== 1'b0 || p0_valid !== 1'b0) $display("FAIL st_no_resp got %b%b want 00", p0_valid, p1_valid); else n_pass++;
        dc_ready = 1'b1; p0_op = 4'h0;
        #1;
        $display("txn p0 load at limit");
        n_total++; if (dc_req !== 1'b0) $display("FAIL st_load_blocked got %b want 0", dc_req); else n_pass++;
        p0_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        p0_req = 1'b1; p0_op = 4'h1; p1_req = 1'b1; p1_op = 4'h0; p1_tag = 5'd2;
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn reset mid-burst");
        n_total++; if (p0_ready !== 1'b0) $display("FAIL rm_p0_ready got %b want 0", p0_ready); else n_pass++;
        n_total++; if (p1_ready !== 1'b0) $display("FAIL rm_p1_ready got %b want 0", p1_ready); else n_pass++;
        n_total++; if (dc_req !== 1'b0)   $display("FAIL rm_dc_req got %b want 0", dc_req); else n_pass++;
        tick();
        rst_n = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
        dc_valid = 1'b1; dc_rtag = 6'h01;
        #1;
        $display("txn stale response after reset");
        n_total++; if (p0_valid !== 1'b0) $display("FAIL rm_stale got %b want 0", p0_valid); else n_pass++;
        tick();
        dc_valid = 1'b0; p0_req = 1'b1; p0_op = 4'h0;
        for (int k = 0; k < 4; k++) begin
            p0_tag = 5'(10 + k);
            #1;
            $display("txn p0 load tag %0d after reset", 10 + k);
            n_total++; if (p0_ready !== 1'b1) $display("FAIL rm_load%0d got %b want 1", k, p0_ready); else n_pass++;
            tick();
        end
        #1;
        n_total++; if (p0_ready !== 1'b0) $display("FAIL rm_limit got %b want 0", p0_ready); else n_pass++;
        p0_req = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        bit exp1;
        p0_req = 1'b1; p0_op = 4'h1; p1_req = 1'b1; p1_op = 4'h0; p1_tag = 5'd3;
        for (int b = 1; b <= 10; b++) begin
`ifdef DC_ARB_STARVE_EN
            exp1 = (b == 9);
`else
            exp1 = 1'b0;
`endif
            #1;
            $display("txn contention beat %0d", b);
            n_total++; if (p1_ready !== exp1)  $display("FAIL sv_p1_beat%0d got %b want %b", b, p1_ready, exp1); else n_pass++;
            n_total++; if (p0_ready !== !exp1) $display("FAIL sv_p0_beat%0d got %b want %b", b, p0_ready, !exp1); else n_pass++;
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_limit();
        test_responses();
        test_flush();
        test_store();
        test_reset_mid();
        test_starve();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dc_arb.md
DC_ARB -- requirements
Module: dc_arb

Interface
REQ-001 Parameter MAX_OUT, default 4, max outstanding loads per requester (power of two, 2..8).
REQ-002 Parameter STARVE_LIM, default 8, consecutive port-0 grants tolerated while port 1 waits.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 p0_req, p0_op[3:0], p0_addr[31:0], p0_tag[4:0], p0_wdata[31:0]  in  port 0 (load-store queue) request.
REQ-006 p0_ready  out  1  port-0 request accepted this cycle.
REQ-007 p0_flush  in  1  squash all port-0 loads in flight.
REQ-008 p0_valid, p0_error  out  1 each; p0_rtag  out  5; p0_rdata  out  32  port-0 response.
REQ-009 p1_req, p1_op[3:0], p1_addr[31:0], p1_tag[4:0], p1_wdata[31:0]  in; p1_ready  out  port 1 (secondary requester).
REQ-010 p1_valid, p1_error  out  1 each; p1_rtag  out  5; p1_rdata  out  32  port-1 response.
REQ-011 dc_req  out  1; dc_op  out  4; dc_addr  out  32; dc_tag  out  6; dc_wdata  out  32  downstream request.
REQ-012 dc_ready  in  1; dc_valid, dc_error  in  1 each; dc_rtag  in  6; dc_rdata  in  32  downstream handshake and response.

Function
REQ-013 op[0]=1 is a store (no response); op[0]=0 is a load (exactly one response, returned in issue order across both ports).
REQ-014 Port eligible when req high and, for loads, its outstanding count < MAX_OUT; stores are never count-limited.
REQ-015 Default priority: port 0 over port 1; dc_req = OR of eligible ports; dc_op/addr/wdata are the granted port's fields, purely combinational.
REQ-016 dc_tag = {port number, port tag}; grant beat = dc_req & dc_ready; pX_ready = grant to X & dc_ready.
REQ-017 Per-port outstanding counter (width log2(MAX_OUT)+1): +1 on load grant beat, -1 on dc_valid with dc_rtag[5]=X; both in one cycle leaves it unchanged.
REQ-018 Responses route by dc_rtag[5] to pX_valid/error/rdata with pX_rtag = dc_rtag[4:0], same cycle, no buffering; responders never stall.
REQ-019 p0_flush: squash counter loads port-0 outstanding count (already net of any same-cycle port-0 return); p0_ready forced 0 that cycle.
REQ-020 While squash counter > 0, port-0 responses are consumed (counter and outstanding each decremented) with p0_valid held 0.
REQ-021 Flush while squash counter nonzero reloads it with current outstanding count; never underflows.
REQ-022 Port-0 responses arriving with outstanding count 0 are dropped and counters stay at 0.
REQ-023 Port 1 is unaffected by p0_flush.

Reset
REQ-024 rst_n low asynchronously clears outstanding, squash and starvation counters; all ready/valid outputs read 0 while rst_n low.
REQ-025 Loads in flight at reset are forgotten; any responses after reset release are dropped per REQ-022.

Configuration
REQ-026 Macro DC_ARB_STARVE_EN defined: starvation counter increments on each port-0 grant beat while port 1 eligible and not granted, clears on port-1 grant or when port 1 is not eligible; at STARVE_LIM, next cycle grants port 1 if eligible.
REQ-027 Macro DC_ARB_STARVE_EN undefined: strict port-0 priority, no starvation counter logic present.

Verification
REQ-028 Both ports request loads, dc_ready=1, MAX_OUT=4 -> four port-0 grants, dc_tag 0x00..0x03; then port 0 blocked, port 1 granted with dc_tag 0x20.
REQ-029 Two port-0 loads outstanding, p0_flush -> next two port-0 responses give p0_valid=0; a third, freshly issued load returns p0_valid=1 with its tag.
REQ-030 Response with dc_rtag=0x25, rdata 0xDEADBEEF -> p1_valid=1, p1_rtag=5, p1_rdata=0xDEADBEEF same cycle; p0_valid=0.
REQ-031 DC_ARB_STARVE_EN, STARVE_LIM=8, both ports requesting continuously -> port 1 granted on 9th beat, then port 0 resumes.
REQ-032 Port-0 store stream with port-0 load count at MAX_OUT -> stores still granted, no responses expected; dc_ready=0 holds fields stable.
REQ-033 rst_n asserted mid-burst -> outputs 0 immediately; after release, stale dc_valid responses dropped, new loads granted normally.
